mult_hilo_ctrl: RTL and testbench
=================================

Name: mult_hilo_ctrl

Overview:
Sequencing controller for the registered 32x32 signed multiplier array.
- Accepts multiply requests through a start/busy/done handshake and drives the multiplier operands.
- Waits for the multiplier's pipeline latency, then converts the signed product to an unsigned one when the operation needs it.
- Writes the result into architectural HI/LO registers.
- Also serves CPU move-to-HI/LO writes and abort (pipeline flush) requests.

Parameters:
MUL_LAT, 1, multiplier latency in cycles from the edge that samples the operands to a valid z; legal range 1..7.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request pulse; sampled only in IDLE.
op  in  2  op[0]: 0 = signed, 1 = unsigned; op[1]: accumulate (MULT_MADD_EN only).
a  in  32  operand A; captured when start is accepted.
b  in  32  operand B; captured when start is accepted.
abort  in  1  cancels the in-flight operation.
hi_we  in  1  move-to-HI write enable.
lo_we  in  1  move-to-LO write enable.
wdata  in  32  write data for HI/LO moves.
mul_a  out  32  operand A to the multiplier.
mul_b  out  32  operand B to the multiplier.
mul_z  in  64  signed 64-bit product from the multiplier.
busy  out  1  high from accepted start until completion or abort.
done  out  1  one-cycle pulse after HI/LO is updated.
hi  out  32  HI register.
lo  out  32  LO register.

Behaviour:
- Reset (async, reset==0): state=IDLE; cnt, opA/opB/op registers, hi, lo cleared to 0; busy=0, done=0. Applies immediately, including mid-operation; the in-flight result is discarded.
- mul_a/mul_b are driven directly from the opA/opB registers. They stay stable for the whole operation because the multiplier re-samples on every edge.
- States: IDLE, RUN, WB.
- IDLE:
  - start=1 at edge T0: latch a, b, op; cnt <= MUL_LAT; go to RUN; busy=1 from T0.
  - start while already busy is ignored; the requester must hold its request until busy=0.
- RUN:
  - Each edge: cnt <= cnt-1.
  - When cnt==1 at an edge, go to WB. The multiplier samples the operands at T0+1, and mul_z is valid during the WB cycle.
- WB (one cycle):
  - At the exiting edge (T0+MUL_LAT+1), load {hi,lo} with the final result, pulse done=1 for the following cycle, set busy=0, return to IDLE.
  - A new start is accepted at the earliest in the cycle where done=1.
- Unsigned correction (op[0]=1):
  - result = mul_z + ((a[31] ? b : 0) << 32) + ((b[31] ? a : 0) << 32), computed mod 2^64 on the latched operands.
  - Only the upper 32 bits change: HI adjustment mod 2^32.
  - Signed (op[0]=0): result = mul_z unchanged.
- Abort:
  - In RUN or WB, abort=1 at an edge returns to IDLE with busy=0 and done=0; hi/lo stay unchanged.
  - Abort in IDLE has no effect.
  - Abort wins over WB completion at the same edge.
- HI/LO moves:
  - Accepted only when busy=0 and start is not being accepted that cycle.
  - hi_we writes wdata to hi; lo_we writes wdata to lo; both may be asserted together.
  - Moves while busy=1 are dropped (a software hazard, not buffered).
  - start has priority over a move in the same cycle: the move is dropped.
- done and busy are never high in the same cycle.

Optional Feature:
MULT_MADD_EN
- Defined: op[1]=1 selects accumulate. At WB, {hi,lo} <= {hi,lo} + result, with result corrected per op[0], mod 2^64. The old {hi,lo} is read at the WB edge.
- Undefined: op[1] is ignored; every operation overwrites {hi,lo}.

Test Plan:
1. MUL_LAT=1; a=0xFFFFFFFF, b=0x00000002, op=00, start at edge 0 -> busy=1 over edges 0..2; at edge 2 hi=0xFFFFFFFF, lo=0xFFFFFFFE; done=1 for exactly one cycle, busy=0.
2. Same operands, op=01 -> hi=0x00000001, lo=0xFFFFFFFE. Also a=b=0xFFFFFFFF unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
3. MUL_LAT=3; a=7, b=6; second start with a=1, b=1 pulsed while busy -> ignored; result hi=0, lo=42 at edge 4. Repeat with abort at edge 2 -> hi/lo keep their old values, done never pulses.
4. reset driven low mid-RUN (after hi/lo were 0x12345678/0x9ABCDEF0) -> hi=lo=0, busy=0, done=0 immediately, without waiting for a clock edge.
5. Idle: hi_we=1, lo_we=1, wdata=0xCAFEBABE -> both registers=0xCAFEBABE. With start in the same cycle -> move dropped, multiply proceeds. hi_we while busy -> dropped.
6. MULT_MADD_EN: hi=0, lo=5; op=10, a=3, b=4 -> lo=17. Then hi=0, lo=0xFFFFFFFF; op=11, a=1, b=1 -> hi=1, lo=0.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
// HI/LO sequencing controller for a registered 32x32 signed multiplier.
// Optional build macro MULT_MADD_EN: op[1]=1 accumulates the result into {hi,lo}.
module mult_hilo_ctrl #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [1:0]  op_r;
    logic [63:0] result;
    logic [63:0] wb_val;

    assign mul_a = opa;
    assign mul_b = opb;

    // Unsigned fix-up of the signed product only touches the upper word.
    always_comb begin
        result = mul_z;
        if (op_r[0])
            result[63:32] = mul_z[63:32] + (opa[31] ? opb : '0) + (opb[31] ? opa : '0);
    end

`ifdef MULT_MADD_EN
    always_comb begin
        wb_val = op_r[1] ? ({hi, lo} + result) : result;
    end
`else
    logic unused_op1;
    assign unused_op1 = op_r[1];

    always_comb begin
        wb_val = result;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            op_r  <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        op_r  <= op;
                        cnt   <= 3'(MUL_LAT);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) state <= WB;
                    end
                end
                WB: begin
                    if (!abort) begin
                        {hi, lo} <= wb_val;
                        done     <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl: instance 0 uses MUL_LAT=1, instance 1 uses MUL_LAT=3.
module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v [2];
    logic [1:0]  op_v    [2];
    logic [31:0] a_v     [2];
    logic [31:0] b_v     [2];
    logic        abort_v [2];
    logic        hiwe_v  [2];
    logic        lowe_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] mula_v  [2];
    logic [31:0] mulb_v  [2];
    logic [63:0] mulz_v  [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [31:0] hi_v    [2];
    logic [31:0] lo_v    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_hilo_ctrl #(.MUL_LAT(1)) u_lat1 (
        .clk(clk), .reset(rst_n), .start(start_v[0]), .op(op_v[0]), .a(a_v[0]), .b(b_v[0]),
        .abort(abort_v[0]), .hi_we(hiwe_v[0]), .lo_we(lowe_v[0]), .wdata(wdata_v[0]),
        .mul_a(mula_v[0]), .mul_b(mulb_v[0]), .mul_z(mulz_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .hi(hi_v[0]), .lo(lo_v[0])
    );

    mult_hilo_ctrl #(.MUL_LAT(3)) u_lat3 (
        .clk(clk), .reset(rst_n), .start(start_v[1]), .op(op_v[1]), .a(a_v[1]), .b(b_v[1]),
        .abort(abort_v[1]), .hi_we(hiwe_v[1]), .lo_we(lowe_v[1]), .wdata(wdata_v[1]),
        .mul_a(mula_v[1]), .mul_b(mulb_v[1]), .mul_z(mulz_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .hi(hi_v[1]), .lo(lo_v[1])
    );

    // Registered signed multiplier models with 1 and 3 stages.
    function automatic logic [63:0] sprod(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe, ye;
        xe = {{32{x[31]}}, x};
        ye = {{32{y[31]}}, y};
        return xe * ye;
    endfunction

    logic [63:0] pipe3 [3];
    always @(posedge clk) begin
        mulz_v[0] <= sprod(mula_v[0], mulb_v[0]);
        pipe3[0]  <= sprod(mula_v[1], mulb_v[1]);
        pipe3[1]  <= pipe3[0];
        pipe3[2]  <= pipe3[1];
    end
    assign mulz_v[1] = pipe3[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int idx, input logic hw, input logic lw, input logic [31:0] d);
        hiwe_v[idx] = hw;
        lowe_v[idx] = lw;
        wdata_v[idx] = d;
        step();
        hiwe_v[idx] = 1'b0;
        lowe_v[idx] = 1'b0;
    endtask

    // Full operation: busy across edges 0..lat, done+writeback at edge lat+1.
    task automatic mul_op(input int idx, input int lat, input logic [31:0] av, input logic [31:0] bv,
                          input logic [1:0] opv, input logic [31:0] ehi, input logic [31:0] elo);
        a_v[idx] = av;
        b_v[idx] = bv;
        op_v[idx] = opv;
        start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
        hiwe_v[idx] = 1'b0;
        lowe_v[idx] = 1'b0;
        check($sformatf("i%0d busy@start", idx), 64'(busy_v[idx]), 64'd1);
        check($sformatf("i%0d mul_a", idx), 64'(mula_v[idx]), 64'(av));
        for (int i = 0; i < lat; i++) begin
            step();
            check($sformatf("i%0d busy run%0d", idx, i), 64'(busy_v[idx]), 64'd1);
            check($sformatf("i%0d done run%0d", idx, i), 64'(done_v[idx]), 64'd0);
        end
        step();
        check($sformatf("i%0d busy wb", idx), 64'(busy_v[idx]), 64'd0);
        check($sformatf("i%0d done wb", idx), 64'(done_v[idx]), 64'd1);
        check($sformatf("i%0d hi %h*%h", idx, av, bv), 64'(hi_v[idx]), 64'(ehi));
        check($sformatf("i%0d lo %h*%h", idx, av, bv), 64'(lo_v[idx]), 64'(elo));
        step();
        check($sformatf("i%0d done pulse end", idx), 64'(done_v[idx]), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; op_v[i] = '0; a_v[i] = '0; b_v[i] = '0;
            abort_v[i] = 1'b0; hiwe_v[i] = 1'b0; lowe_v[i] = 1'b0; wdata_v[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d rst busy", i), 64'(busy_v[i]), 64'd0);
            check($sformatf("i%0d rst done", i), 64'(done_v[i]), 64'd0);
            check($sformatf("i%0d rst hi", i), 64'(hi_v[i]), 64'd0);
            check($sformatf("i%0d rst lo", i), 64'(lo_v[i]), 64'd0);
        end
        rst_n = 1'b1;
        step();

        // Signed and unsigned at MUL_LAT=1.
        mul_op(0, 1, 32'hFFFFFFFF, 32'h00000002, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFE);
        mul_op(0, 1, 32'hFFFFFFFF, 32'h00000002, 2'b01, 32'h00000001, 32'hFFFFFFFE);
        mul_op(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 32'h00000001);
        mul_op(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000000, 32'h00000001);

        // MUL_LAT=3 with a start pulsed while busy.
        a_v[1] = 32'd7; b_v[1] = 32'd6; op_v[1] = 2'b00; start_v[1] = 1'b1;
        step();
        a_v[1] = 32'd1; b_v[1] = 32'd1;
        step();
        start_v[1] = 1'b0;
        check("lat3 ignored start mul_a", 64'(mula_v[1]), 64'd7);
        check("lat3 ignored start busy", 64'(busy_v[1]), 64'd1);
        step();
        step();
        check("lat3 busy edge3", 64'(busy_v[1]), 64'd1);
        step();
        check("lat3 done edge4", 64'(done_v[1]), 64'd1);
        check("lat3 hi", 64'(hi_v[1]), 64'd0);
        check("lat3 lo", 64'(lo_v[1]), 64'd42);
        step();
        check("lat3 no restart", 64'(busy_v[1]), 64'd0);

        // Abort in RUN at edge 2.
        a_v[1] = 32'd5; b_v[1] = 32'd5; start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        step();
        abort_v[1] = 1'b1;
        step();
        abort_v[1] = 1'b0;
        check("abort busy", 64'(busy_v[1]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort no done %0d", i), 64'(done_v[1]), 64'd0);
            step();
        end
        check("abort hi kept", 64'(hi_v[1]), 64'd0);
        check("abort lo kept", 64'(lo_v[1]), 64'd42);

        // Abort on the WB exit edge beats the writeback.
        a_v[0] = 32'd9; b_v[0] = 32'd9; op_v[0] = 2'b00; start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        step();
        abort_v[0] = 1'b1;
        step();
        abort_v[0] = 1'b0;
        check("wb abort done", 64'(done_v[0]), 64'd0);
        check("wb abort busy", 64'(busy_v[0]), 64'd0);
        check("wb abort lo kept", 64'(lo_v[0]), 64'h00000001);

        // Asynchronous reset mid-RUN.
        move(1, 1'b1, 1'b0, 32'h12345678);
        move(1, 1'b0, 1'b1, 32'h9ABCDEF0);
        check("pre-reset hi", 64'(hi_v[1]), 64'h12345678);
        check("pre-reset lo", 64'(lo_v[1]), 64'h9ABCDEF0);
        a_v[1] = 32'd2; b_v[1] = 32'd3; start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst hi", 64'(hi_v[1]), 64'd0);
        check("async rst lo", 64'(lo_v[1]), 64'd0);
        check("async rst busy", 64'(busy_v[1]), 64'd0);
        check("async rst done", 64'(done_v[1]), 64'd0);
        rst_n = 1'b1;
        step();

        // Moves in idle, move dropped by same-cycle start, move dropped while busy.
        move(0, 1'b1, 1'b1, 32'hCAFEBABE);
        check("move hi", 64'(hi_v[0]), 64'hCAFEBABE);
        check("move lo", 64'(lo_v[0]), 64'hCAFEBABE);
        hiwe_v[0] = 1'b1; lowe_v[0] = 1'b1; wdata_v[0] = 32'h11111111;
        a_v[0] = 32'd3; b_v[0] = 32'd5; op_v[0] = 2'b00; start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0; hiwe_v[0] = 1'b0; lowe_v[0] = 1'b0;
        check("start beats move hi", 64'(hi_v[0]), 64'hCAFEBABE);
        check("start beats move busy", 64'(busy_v[0]), 64'd1);
        step();
        step();
        check("start+move result lo", 64'(lo_v[0]), 64'd15);
        a_v[0] = 32'd2; b_v[0] = 32'd2; start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        hiwe_v[0] = 1'b1; wdata_v[0] = 32'hDEADBEEF;
        step();
        hiwe_v[0] = 1'b0;
        check("busy move dropped", 64'(hi_v[0]), 64'd0);
        step();
        check("busy move result lo", 64'(lo_v[0]), 64'd4);
        check("busy move result hi", 64'(hi_v[0]), 64'd0);

`ifdef MULT_MADD_EN
        move(0, 1'b1, 1'b1, 32'd0);
        move(0, 1'b0, 1'b1, 32'd5);
        mul_op(0, 1, 32'd3, 32'd4, 2'b10, 32'd0, 32'd17);
        move(0, 1'b1, 1'b0, 32'd0);
        move(0, 1'b0, 1'b1, 32'hFFFFFFFF);
        mul_op(0, 1, 32'd1, 32'd1, 2'b11, 32'd1, 32'd0);
`else
        move(0, 1'b0, 1'b1, 32'd5);
        mul_op(0, 1, 32'd3, 32'd4, 2'b10, 32'd0, 32'd12);
`endif
        mul_op(1, 3, 32'h80000000, 32'h80000000, 2'b01, 32'h40000000, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
